bin_to_bcd_2digit: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the two-digit seven-segment display driver. It accepts an 8-bit unsigned binary count through a valid/ready handshake and converts it with an iterative double-dabble (shift-and-add-3) engine. It presents the result as a packed two-digit BCD byte: ones digit in [3:0], tens digit in [7:4]. That byte feeds the display driver's 8-bit `value` input directly, so the display reads decimal instead of hex.

---
 rtl/bin_to_bcd_2digit_if.sv | 21 ++
 rtl/bin_to_bcd_2digit.sv | 101 ++++++++++
 tb/tb_bin_to_bcd_2digit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_2digit_if.sv
// Handshake and result bundle between the binary-to-BCD converter and its neighbours.
// The master drives the binary request; the slave (converter) returns the BCD result.
interface bin_to_bcd_2digit_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bin;
    logic [7:0] value;
    logic [1:0] hundreds;
    logic       overflow;
    logic       out_valid;

    modport master (
        output in_valid, bin,
        input  in_ready, value, hundreds, overflow, out_valid
    );

    modport slave (
        input  in_valid, bin,
        output in_ready, value, hundreds, overflow, out_valid
    );
endinterface

// File: rtl/bin_to_bcd_2digit.sv
// Iterative double-dabble converter: 8-bit binary to packed {tens, ones} BCD plus hundreds digit.
// Optional macro BCD_SATURATE_EN clamps value to 8'h99 for results of 100 and above.
module bin_to_bcd_2digit (
    input  logic                 CLK,
    input  logic                 RST_N,
    bin_to_bcd_2digit_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [7:0]  shreg_q,     shreg_d;
    logic [11:0] acc_q,       acc_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [7:0]  value_q,     value_d;
    logic [1:0]  hundreds_q,  hundreds_d;
    logic        overflow_q,  overflow_d;
    logic        out_valid_q, out_valid_d;

    logic [11:0] acc_adj;
    logic [19:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [7:0] pack_value(input logic [11:0] acc);
`ifdef BCD_SATURATE_EN
        if (acc[11:8] != 4'd0) return 8'h99;
`endif
        return acc[7:0];
    endfunction

    // All three digits are corrected from their pre-correction values before the shift.
    assign acc_adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    assign shifted = {acc_adj, shreg_q} << 1;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        hundreds_d  = hundreds_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    shreg_d = bus.bin;
                    acc_d   = 12'd0;
                    cnt_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = shifted[19:8];
                shreg_d = shifted[7:0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = S_DONE;
            end
            S_DONE: begin
                value_d     = pack_value(acc_q);
                hundreds_d  = acc_q[9:8];
                overflow_d  = (acc_q[11:8] != 4'd0);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            shreg_q     <= 8'd0;
            acc_q       <= 12'd0;
            cnt_q       <= 3'd0;
            value_q     <= 8'h00;
            hundreds_q  <= 2'd0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            hundreds_q  <= hundreds_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.value     = value_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bin_to_bcd_2digit.sv
// Self-checking bench for bin_to_bcd_2digit against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bin_to_bcd_2digit;
    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    bin_to_bcd_2digit_if bus();

    bin_to_bcd_2digit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_value(input int v);
        int t, o;
        logic [7:0] r;
        t = (v / 10) % 10;
        o = v % 10;
        r = {t[3:0], o[3:0]};
`ifdef BCD_SATURATE_EN
        if (v >= 100) r = 8'h99;
`endif
        return r;
    endfunction

    function automatic logic [1:0] ref_hund(input int v);
        int h;
        h = v / 100;
        return h[1:0];
    endfunction

    function automatic logic ref_ovf(input int v);
        return v >= 100;
    endfunction

    logic [7:0] cap_val;
    logic [1:0] cap_hun;
    logic       cap_ovf;
    int         cap_lat;
    int         cap_width;
    bit         cap_rdy_ok;
    bit         cap_seen;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one conversion and records what the converter produced.
    task automatic do_conv(input logic [7:0] b);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            step();
            guard++;
        end
        bus.bin      = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.bin      = 8'($urandom);
        cap_lat = -1; cap_width = 0; cap_rdy_ok = 1'b1; cap_seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (!cap_seen) begin
                if (bus.out_valid) begin
                    cap_seen  = 1'b1;
                    cap_lat   = c;
                    cap_width = 1;
                    cap_val   = bus.value;
                    cap_hun   = bus.hundreds;
                    cap_ovf   = bus.overflow;
                    if (!bus.in_ready) cap_rdy_ok = 1'b0;
                end else if (bus.in_ready) begin
                    cap_rdy_ok = 1'b0;
                end
            end else if (bus.out_valid) begin
                cap_width++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit pulse;
        bus.in_valid = 1'b0;
        bus.bin      = 8'd0;
        RST_N        = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        checks++;
        if (bus.value !== 8'h00) begin errors++; $display("FAIL reset_value got %h want 00", bus.value); end
        checks++;
        if (bus.hundreds !== 2'd0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_hund_ovf got %0d/%b want 0/0", bus.hundreds, bus.overflow);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_handshake got ov=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        pulse = 1'b0;
        repeat (12) begin
            step();
            if (bus.out_valid !== 1'b0) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin errors++; $display("FAIL idle_no_pulse got out_valid=1 want 0"); end
    endtask

    task automatic test_basic();
        do_conv(8'd42);
        checks++;
        if (!cap_seen || cap_lat != 9) begin errors++; $display("FAIL basic_latency got %0d want 9", cap_lat); end
        checks++;
        if (!cap_rdy_ok) begin errors++; $display("FAIL basic_in_ready got bad in_ready window want 0 during conversion"); end
        checks++;
        if (cap_width != 1) begin errors++; $display("FAIL basic_pulse_width got %0d want 1", cap_width); end
        checks++;
        if (cap_val !== 8'h42 || cap_ovf !== 1'b0 || cap_hun !== 2'd0) begin
            errors++; $display("FAIL basic_result got %h/%0d/%b want 42/0/0", cap_val, cap_hun, cap_ovf);
        end
    endtask

    task automatic test_digits();
        int vals [4] = '{0, 9, 10, 99};
        for (int i = 0; i < 4; i++) begin
            do_conv(8'(vals[i]));
            checks++;
            if (!cap_seen || cap_val !== ref_value(vals[i]) || cap_ovf !== 1'b0) begin
                errors++;
                $display("FAIL digits_%0d got %h ovf=%b want %h ovf=0", vals[i], cap_val, cap_ovf, ref_value(vals[i]));
            end
            repeat (3) step();
            checks++;
            if (bus.value !== ref_value(vals[i]) || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL digits_hold_%0d got %h ov=%b want %h ov=0", vals[i], bus.value, bus.out_valid, ref_value(vals[i]));
            end
        end
    endtask

    task automatic test_overflow();
        int vals [4] = '{255, 100, 200, 199};
        for (int i = 0; i < 4; i++) begin
            do_conv(8'(vals[i]));
            checks++;
            if (!cap_seen || cap_val !== ref_value(vals[i]) || cap_hun !== ref_hund(vals[i]) || cap_ovf !== 1'b1) begin
                errors++;
                $display("FAIL overflow_%0d got %h/%0d/%b want %h/%0d/1", vals[i], cap_val, cap_hun, cap_ovf,
                         ref_value(vals[i]), ref_hund(vals[i]));
            end
        end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 255));
            do_conv(8'(v));
            checks++;
            if (!cap_seen || cap_lat != 9 || cap_val !== ref_value(v) || cap_hun !== ref_hund(v) || cap_ovf !== ref_ovf(v)) begin
                errors++;
                $display("FAIL random_%0d got lat=%0d %h/%0d/%b want lat=9 %h/%0d/%b", v, cap_lat, cap_val, cap_hun,
                         cap_ovf, ref_value(v), ref_hund(v), ref_ovf(v));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         prev_rdy;
        int         n_acc, acc2, p1, p2, n;
        logic [7:0] acc2_bin, val1, val2;
        while (!bus.in_ready) step();
        bus.bin      = 8'd17;
        bus.in_valid = 1'b1;
        prev_rdy = bus.in_ready;
        n_acc = 0; acc2 = -1; p1 = -1; p2 = -1; acc2_bin = 8'h00; val1 = 8'h00; val2 = 8'h00;
        for (int k = 0; k < 35; k++) begin
            @(posedge CLK);
            if (prev_rdy && bus.in_valid) begin
                n_acc++;
                if (n_acc == 2) begin acc2 = k; acc2_bin = bus.bin; end
            end
            #1;
            if (n_acc >= 2) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (p1 < 0) begin p1 = k; val1 = bus.value; end
                else if (p2 < 0) begin p2 = k; val2 = bus.value; end
            end
            prev_rdy = bus.in_ready;
            n = k + 1;
            bus.bin = (n == 3) ? 8'd200 : (n >= 9) ? 8'd63 : 8'($urandom_range(0, 255));
        end
        checks++;
        if (p1 != 9 || val1 !== ref_value(17)) begin
            errors++; $display("FAIL b2b_first got cyc=%0d val=%h want cyc=9 val=%h", p1, val1, ref_value(17));
        end
        checks++;
        if (n_acc != 2 || acc2 < 9 || acc2_bin !== 8'd63) begin
            errors++; $display("FAIL b2b_second_accept got n=%0d at=%0d bin=%0d want n=2 at>=9 bin=63", n_acc, acc2, acc2_bin);
        end
        checks++;
        if (p2 != acc2 + 9 || val2 !== ref_value(63)) begin
            errors++; $display("FAIL b2b_second got cyc=%0d val=%h want cyc=%0d val=%h", p2, val2, acc2 + 9, ref_value(63));
        end
    endtask

    task automatic test_reset_abort();
        bit pulse;
        while (!bus.in_ready) step();
        bus.bin      = 8'd77;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        checks++;
        if (bus.value !== 8'h00 || bus.hundreds !== 2'd0 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got %h/%0d/%b/%b want 00/0/0/0", bus.value, bus.hundreds, bus.overflow, bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
        pulse = 1'b0;
        repeat (12) begin
            step();
            if (bus.out_valid !== 1'b0) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin errors++; $display("FAIL abort_no_pulse got out_valid=1 want 0"); end
        do_conv(8'd77);
        checks++;
        if (!cap_seen || cap_lat != 9 || cap_val !== 8'h77 || cap_ovf !== 1'b0) begin
            errors++; $display("FAIL abort_reconvert got lat=%0d val=%h want lat=9 val=77", cap_lat, cap_val);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST_N  = 1'b0;
        bus.in_valid = 1'b0;
        bus.bin      = 8'd0;
        test_reset();
        test_basic();
        test_digits();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
